// File: rtl/ex_mdu.sv
// ---------------------------------------------------------------------------
// ex_mdu -- multi-cycle RV32M multiply/divide execute unit
//
// Sits beside the single-cycle ALU in the EX stage. A start request latches
// the operands. The unit then iterates one bit per cycle: shift-add for
// multiplies, restoring division for divides. Signed operands are converted
// to magnitudes on entry, and the sign of the result is fixed up in one final
// cycle. Two divide cases are answered immediately, without iterating:
// division by zero and signed overflow (most-negative / -1).
//
// Ports
//   clk      in   1       clock, all state on rising edge
//   rst      in   1       synchronous active-high reset (overrides rdy/flush_i)
//   rdy      in   1       global ready; when low every register holds
//   flush_i  in   1       abort current operation, no done pulse for it
//   start_i  in   1       request, only sampled while idle
//   op_i     in   3       funct3: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//   rs1_i    in   XLEN    multiplicand / dividend
//   rs2_i    in   XLEN    multiplier / divisor
//   wd_i     in   REG_AW  destination register
//   wreg_i   in   1       destination write enable
//   busy_o   out  1       operation in flight (includes the done cycle)
//   done_o   out  1       one-cycle pulse; data_o/wd_o/wreg_o valid
//   data_o   out  XLEN    result (holds between operations)
//   wd_o     out  REG_AW  destination of the finished op
//   wreg_o   out  1       write enable of the finished op, 0 when wd_o==0
// ---------------------------------------------------------------------------
module ex_mdu #(
  parameter int XLEN   = 32,
  parameter int CNT_W  = 6,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush_i,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [XLEN-1:0]   rs1_i,
  input  logic [XLEN-1:0]   rs2_i,
  input  logic [REG_AW-1:0] wd_i,
  input  logic              wreg_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [XLEN-1:0]   data_o,
  output logic [REG_AW-1:0] wd_o,
  output logic              wreg_o
);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN);
  localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Iteration state. For multiplies {hi_reg,lo_reg} is the shifting product,
  // with the multiplier consumed from the bottom of lo_reg. For divides
  // hi_reg is the partial remainder and lo_reg shifts the dividend out of its
  // top while the quotient bits shift in at the bottom.
  logic [CNT_W-1:0]  cnt_reg;
  logic [2:0]        op_reg;
  logic [XLEN-1:0]   hi_reg;
  logic [XLEN-1:0]   lo_reg;
  logic [XLEN-1:0]   opb_reg;      // multiplicand or divisor magnitude
  logic              neg_q_reg;    // negate product / quotient at the end
  logic              neg_r_reg;    // negate remainder at the end
  logic [REG_AW-1:0] wd_hold_reg;
  logic              wreg_hold_reg;

  logic              done_reg;
  logic [XLEN-1:0]   data_reg;
  logic [REG_AW-1:0] wd_out_reg;
  logic              wreg_out_reg;

  // -------------------------------------------------------------------------
  // Operand decode on the request inputs
  // -------------------------------------------------------------------------
  logic            in_div;
  logic            in_sa;
  logic            in_sb;
  logic            in_a_neg;
  logic            in_b_neg;
  logic [XLEN-1:0] in_a_mag;
  logic [XLEN-1:0] in_b_mag;
  logic            in_div0;
  logic            in_ovf;
  logic            in_fast;
  logic [XLEN-1:0] in_fast_res;

  always_comb begin
    in_div   = op_i[2];
    in_sa    = (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
               (op_i == OP_DIV)  || (op_i == OP_REM);
    in_sb    = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    in_a_neg = in_sa & rs1_i[XLEN-1];
    in_b_neg = in_sb & rs2_i[XLEN-1];
    // Negating INT_MIN yields INT_MIN, which is also its correct unsigned
    // magnitude, so no special case is needed here.
    in_a_mag = in_a_neg ? -rs1_i : rs1_i;
    in_b_mag = in_b_neg ? -rs2_i : rs2_i;

    in_div0  = in_div && (rs2_i == '0);
    // in_sa && in_div selects exactly the signed DIV/REM pair.
    in_ovf   = in_sa && in_div && (rs1_i == INT_MIN) && (rs2_i == '1);
    in_fast  = in_div0 | in_ovf;

    // op_i[1] separates REM/REMU (6,7) from DIV/DIVU (4,5).
    if (in_div0) begin
      in_fast_res = op_i[1] ? rs1_i : '1;
    end else begin
      in_fast_res = op_i[1] ? '0 : rs1_i;
    end
  end

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  logic last_iter;
  assign last_iter = (cnt_reg == LAST_ITER);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (rdy) begin
      if (flush_i) begin
        state_next = S_IDLE;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (start_i) begin
              state_next = in_fast ? S_DONE : S_CALC;
            end
          end
          S_CALC: begin
            if (last_iter) begin
              state_next = S_DONE;
            end
          end
          S_DONE:  state_next = S_IDLE;
          default: state_next = S_IDLE;
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // One iteration step
  // -------------------------------------------------------------------------
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_trial;
  logic [XLEN-1:0] hi_step;
  logic [XLEN-1:0] lo_step;

  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opb_reg} : '0);
    // The shifted partial remainder is always below 2*divisor, so the top
    // bit of the trial difference is a clean borrow flag.
    div_trial = {hi_reg, lo_reg[XLEN-1]} - {1'b0, opb_reg};
    if (op_reg[2]) begin
      if (!div_trial[XLEN]) begin
        hi_step = div_trial[XLEN-1:0];
        lo_step = {lo_reg[XLEN-2:0], 1'b1};
      end else begin
        hi_step = {hi_reg[XLEN-2:0], lo_reg[XLEN-1]};
        lo_step = {lo_reg[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_step = mul_sum[XLEN:1];
      lo_step = {mul_sum[0], lo_reg[XLEN-1:1]};
    end
  end

  // -------------------------------------------------------------------------
  // Sign fix-up and result selection (used in the final CALC cycle)
  // -------------------------------------------------------------------------
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   result;

  always_comb begin
    prod     = {hi_reg, lo_reg};
    prod_fix = neg_q_reg ? -prod : prod;
    quo_fix  = neg_q_reg ? -lo_reg : lo_reg;
    rem_fix  = neg_r_reg ? -hi_reg : hi_reg;
    case (op_reg)
      OP_MUL:                       result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result = quo_fix;
      OP_REM, OP_REMU:              result = rem_fix;
      default:                      result = '0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= '0;
      op_reg        <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      opb_reg       <= '0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
      wd_hold_reg   <= '0;
      wreg_hold_reg <= 1'b0;
      done_reg      <= 1'b0;
      data_reg      <= '0;
      wd_out_reg    <= '0;
      wreg_out_reg  <= 1'b0;
    end else if (rdy) begin
      // DONE is only ever entered for one cycle, so this yields the pulse;
      // a flush forces IDLE and therefore suppresses it.
      done_reg <= (state_next == S_DONE);
      if (!flush_i) begin
        case (state_reg)
          S_IDLE: begin
            if (start_i) begin
              op_reg        <= op_i;
              wd_hold_reg   <= wd_i;
              wreg_hold_reg <= wreg_i;
              cnt_reg       <= '0;
              hi_reg        <= '0;
              lo_reg        <= in_div ? in_a_mag : in_b_mag;
              opb_reg       <= in_div ? in_b_mag : in_a_mag;
              neg_q_reg     <= in_a_neg ^ in_b_neg;
              neg_r_reg     <= in_a_neg;
              if (in_fast) begin
                data_reg     <= in_fast_res;
                wd_out_reg   <= wd_i;
                wreg_out_reg <= wreg_i && (wd_i != '0);
              end
            end
          end
          S_CALC: begin
            if (!last_iter) begin
              hi_reg  <= hi_step;
              lo_reg  <= lo_step;
              cnt_reg <= cnt_reg + CNT_W'(1);
            end else begin
              data_reg     <= result;
              wd_out_reg   <= wd_hold_reg;
              wreg_out_reg <= wreg_hold_reg && (wd_hold_reg != '0);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy_o = (state_reg != S_IDLE);
  assign done_o = done_reg;
  assign data_o = data_reg;
  assign wd_o   = wd_out_reg;
  assign wreg_o = wreg_out_reg;

endmodule

// File: tb/tb_ex_mdu.sv
// ---------------------------------------------------------------------------
// tb_ex_mdu -- self-checking bench for ex_mdu (XLEN=32)
// Expected results come from a plain-arithmetic RV32M model (64-bit integer
// multiply, SV signed divide/modulo) plus a small table of known answers.
// ---------------------------------------------------------------------------
module tb_ex_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        flush_i;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] data_o;
  logic [4:0]  wd_o;
  logic        wreg_o;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ex_mdu #(.XLEN(32), .CNT_W(6), .REG_AW(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .rdy     (rdy),
    .flush_i (flush_i),
    .start_i (start_i),
    .op_i    (op_i),
    .rs1_i   (rs1_i),
    .rs2_i   (rs2_i),
    .wd_i    (wd_i),
    .wreg_i  (wreg_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .data_o  (data_o),
    .wd_o    (wd_o),
    .wreg_o  (wreg_o)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issues one request (caller is at #1 after a rising edge, DUT idle) and
  // reports what the DUT produced. lat counts cycles after the accept edge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wd, input logic wr,
                        output logic [31:0] d, output int lat, output logic [4:0] wdo,
                        output logic wro, output logic busy_ok, output logic after_ok);
    op_i = op; rs1_i = a; rs2_i = b; wd_i = wd; wreg_i = wr; start_i = 1'b1;
    @(posedge clk); #1;
    // Scramble the request inputs: only the captured values may matter.
    start_i = 1'b0; op_i = ~op; rs1_i = $urandom; rs2_i = $urandom; wd_i = ~wd; wreg_i = ~wr;
    lat = 1;
    busy_ok = 1'b1;
    while (!done_o && lat < 200) begin
      if (!busy_o) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (!busy_o) busy_ok = 1'b0;
    d = data_o; wdo = wd_o; wro = wreg_o;
    @(posedge clk); #1;
    after_ok = !busy_o && !done_o && (data_o === d);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; rdy = 1'b0; flush_i = 1'b1; start_i = 1'b1;
    op_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd4; wd_i = 5'd1; wreg_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({busy_o, done_o, data_o, wd_o, wreg_o} !== 40'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got busy=%b done=%b data=%h wd=%0d wreg=%b required all 0",
               busy_o, done_o, data_o, wd_o, wreg_o);
    end
    start_i = 1'b0; flush_i = 1'b0; rdy = 1'b1; rst = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: got busy=%b done=%b required 0 0", busy_o, done_o);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t        vecs[14];
    logic [31:0] d;
    int          lat;
    logic [4:0]  wdo;
    logic        wro;
    logic        bok;
    logic        aok;
    vecs = '{
      '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34},
      '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34},
      '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34},
      '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34},
      '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34},
      '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34},
      '{3'd5, 32'd100,       32'd7,         32'd14,        34},
      '{3'd7, 32'd100,       32'd7,         32'd2,         34},
      '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1},
      '{3'd6, 32'd5,         32'd0,         32'd5,         1},
      '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1},
      '{3'd7, 32'd5,         32'd0,         32'd5,         1},
      '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
      '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1}
    };
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'd3, 1'b1, d, lat, wdo, wro, bok, aok);
      tests_run++;
      if (d !== vecs[i].exp || lat != vecs[i].lat) begin
        tests_failed++;
        $display("FAIL directed[%0d] op=%0d a=%h b=%h: got data=%h lat=%0d required data=%h lat=%0d",
                 i, vecs[i].op, vecs[i].a, vecs[i].b, d, lat, vecs[i].exp, vecs[i].lat);
      end
      tests_run++;
      if (!bok || !aok || wdo !== 5'd3 || wro !== 1'b1) begin
        tests_failed++;
        $display("FAIL directed_ctl[%0d]: got busy_ok=%b after_ok=%b wd=%0d wreg=%b required 1 1 3 1",
                 i, bok, aok, wdo, wro);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wd;
    logic        wr;
    logic [31:0] d;
    int          lat;
    logic [4:0]  wdo;
    logic        wro;
    logic        bok;
    logic        aok;
    for (int i = 0; i < 48; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      wd = 5'($urandom);
      wr = 1'($urandom);
      run_op(op, a, b, wd, wr, d, lat, wdo, wro, bok, aok);
      tests_run++;
      if (d !== ref_result(op, a, b) || lat != ref_latency(op, a, b)) begin
        tests_failed++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got data=%h lat=%0d required data=%h lat=%0d",
                 i, op, a, b, d, lat, ref_result(op, a, b), ref_latency(op, a, b));
      end
      tests_run++;
      if (!bok || !aok || wdo !== wd || wro !== (wr && wd != 0)) begin
        tests_failed++;
        $display("FAIL random_ctl[%0d]: got busy_ok=%b after_ok=%b wd=%0d wreg=%b required 1 1 %0d %b",
                 i, bok, aok, wdo, wro, wd, (wr && wd != 0));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] a;
    logic [31:0] b;
    int          n;
    logic        held;
    a = $urandom; b = $urandom;
    op_i = 3'd1; rs1_i = a; rs2_i = b; wd_i = 5'd9; wreg_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    n = 1;
    while (!done_o && n < 200) begin
      if (n == 10) rdy = 1'b0;
      if (n == 15) rdy = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    rdy = 1'b1;
    tests_run++;
    if (n != 39 || data_o !== ref_result(3'd1, a, b)) begin
      tests_failed++;
      $display("FAIL stall_calc: got lat=%0d data=%h required lat=39 data=%h",
               n, data_o, ref_result(3'd1, a, b));
    end
    // Freeze while the done pulse is being presented.
    rdy = 1'b0;
    held = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (!done_o || !busy_o || data_o !== ref_result(3'd1, a, b)) held = 1'b0;
    end
    tests_run++;
    if (!held) begin
      tests_failed++;
      $display("FAIL stall_done_hold: got done=%b busy=%b data=%h required 1 1 %h",
               done_o, busy_o, data_o, ref_result(3'd1, a, b));
    end
    rdy = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_resume: got done=%b busy=%b required 0 0", done_o, busy_o);
    end
  endtask

  task automatic test_flush();
    int          n;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    int          lat;
    logic [4:0]  wdo;
    logic        wro;
    logic        bok;
    logic        aok;
    logic        quiet;
    op_i = 3'd4; rs1_i = $urandom; rs2_i = $urandom | 32'd1; wd_i = 5'd4; wreg_i = 1'b1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    n = 1;
    while (n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    tests_run++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_abort: got busy=%b done=%b required 0 0", busy_o, done_o);
    end
    // Restart immediately; a leaked done from the aborted op would show as a
    // wrong latency or value here.
    a = $urandom; b = $urandom;
    run_op(3'd7, a, b, 5'd12, 1'b1, d, lat, wdo, wro, bok, aok);
    tests_run++;
    if (d !== ref_result(3'd7, a, b) || lat != ref_latency(3'd7, a, b) || !bok || !aok) begin
      tests_failed++;
      $display("FAIL flush_restart: got data=%h lat=%0d busy_ok=%b after_ok=%b required data=%h lat=%0d 1 1",
               d, lat, bok, aok, ref_result(3'd7, a, b), ref_latency(3'd7, a, b));
    end
    // flush and start together in IDLE: the start is dropped.
    op_i = 3'd0; rs1_i = 32'd2; rs2_i = 32'd3; start_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    quiet = !busy_o && !done_o;
    repeat (4) begin
      @(posedge clk); #1;
      if (busy_o || done_o) quiet = 1'b0;
    end
    tests_run++;
    if (!quiet) begin
      tests_failed++;
      $display("FAIL flush_start_drop: got busy=%b done=%b required 0 0", busy_o, done_o);
    end
  endtask

  task automatic test_rst_mid();
    int n;
    op_i = 3'd3; rs1_i = $urandom; rs2_i = $urandom; wd_i = 5'd7; wreg_i = 1'b1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    n = 1;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    rst = 1'b1; rdy = 1'b0;   // reset must win over a stalled pipeline
    @(posedge clk); #1;
    tests_run++;
    if ({busy_o, done_o, data_o, wd_o, wreg_o} !== 40'd0) begin
      tests_failed++;
      $display("FAIL rst_mid: got busy=%b done=%b data=%h wd=%0d wreg=%b required all 0",
               busy_o, done_o, data_o, wd_o, wreg_o);
    end
    rst = 1'b0; rdy = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_busy_start();
    logic [31:0] a;
    logic [31:0] b;
    int          n;
    a = $urandom; b = ($urandom >> 20) | 32'd1;
    op_i = 3'd5; rs1_i = a; rs2_i = b; wd_i = 5'd8; wreg_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    n = 1;
    while (!done_o && n < 200) begin
      if (n == 5) begin
        start_i = 1'b1; op_i = 3'd0; rs1_i = 32'd9; rs2_i = 32'd9;
      end
      if (n == 6) start_i = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    tests_run++;
    if (n != 34 || data_o !== ref_result(3'd5, a, b)) begin
      tests_failed++;
      $display("FAIL busy_start_calc: got lat=%0d data=%h required lat=34 data=%h",
               n, data_o, ref_result(3'd5, a, b));
    end
    // start during the DONE cycle must be neither taken nor queued.
    start_i = 1'b1; op_i = 3'd0; rs1_i = 32'd9; rs2_i = 32'd9;
    @(posedge clk); #1;
    start_i = 1'b0;
    tests_run++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_start_done: got busy=%b done=%b required 0 0", busy_o, done_o);
    end
    @(posedge clk); #1;
    tests_run++;
    if (busy_o !== 1'b0 || data_o !== ref_result(3'd5, a, b)) begin
      tests_failed++;
      $display("FAIL busy_start_queued: got busy=%b data=%h required 0 %h",
               busy_o, data_o, ref_result(3'd5, a, b));
    end
  endtask

  task automatic test_wd_zero();
    logic [31:0] d;
    int          lat;
    logic [4:0]  wdo;
    logic        wro;
    logic        bok;
    logic        aok;
    run_op(3'd0, 32'd6, 32'd7, 5'd0, 1'b1, d, lat, wdo, wro, bok, aok);
    tests_run++;
    if (wro !== 1'b0 || wdo !== 5'd0 || d !== 32'd42) begin
      tests_failed++;
      $display("FAIL wd_zero: got wreg=%b wd=%0d data=%h required 0 0 0000002a", wro, wdo, d);
    end
    run_op(3'd4, 32'd9, 32'd0, 5'd0, 1'b1, d, lat, wdo, wro, bok, aok);
    tests_run++;
    if (wro !== 1'b0 || lat != 1 || d !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL wd_zero_fast: got wreg=%b lat=%0d data=%h required 0 1 ffffffff", wro, lat, d);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_flush();
    test_rst_mid();
    test_busy_start();
    test_wd_zero();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
